// File: rtl/dram_block_requester.sv
// Cache-side initiator for the subblock-serialised DRAM interface: takes one block
// read/write from the L2, streams writes out as strobed subblocks, reassembles reads.
module dram_block_requester #(
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 512,
  parameter int SUBBLOCKS  = 4,
  parameter int SUB_LOG2   = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_BITS-1:0]             req_addr,
  input  logic [BLOCK_BITS-1:0]            req_wdata,
  output logic                             resp_valid,
  output logic                             resp_err,
  output logic [BLOCK_BITS-1:0]            resp_rdata,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [SUB_LOG2-1:0]              mem_dinDstrobe,
  output logic [BLOCK_BITS/SUBBLOCKS-1:0]  mem_din,
  input  logic [SUB_LOG2-1:0]              mem_doutDstrobe,
  input  logic [BLOCK_BITS/SUBBLOCKS-1:0]  mem_dout,
  input  logic                             mem_dready,
  input  logic                             mem_accR,
  input  logic                             mem_accW
);

  localparam int SW       = BLOCK_BITS / SUBBLOCKS;
  localparam int OFF_BITS = $clog2(BLOCK_BITS / 8);
  localparam int CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [SUB_LOG2-1:0]  LAST_SUB = SUB_LOG2'(SUBBLOCKS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_ACC, WR_BURST, RD_WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [SUB_LOG2-1:0]   beat_q, beat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [BLOCK_BITS-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [SUB_LOG2-1:0]   mem_dinDstrobe_q, mem_dinDstrobe_d;
  logic [SW-1:0]         mem_din_q, mem_din_d;

  logic [SW-1:0] wsub [SUBBLOCKS];
  logic          strobe_bad;
  logic          timed_out;

  for (genvar gi = 0; gi < SUBBLOCKS; gi++) begin : g_wsub
    assign wsub[gi] = wdata_q[gi*SW +: SW];
  end

  assign strobe_bad = (mem_doutDstrobe != beat_q);
  assign timed_out  = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    wdata_d          = wdata_q;
    err_d            = err_q;
    beat_d           = beat_q;
    cnt_d            = cnt_q;
    req_ready_d      = req_ready_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = resp_err_q;
    resp_rdata_d     = resp_rdata_q;
    mem_addr_d       = mem_addr_q;
    mem_en_d         = 1'b0;
    mem_we_d         = 1'b0;
    mem_dinDstrobe_d = mem_dinDstrobe_q;
    mem_din_d        = mem_din_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        resp_err_d  = 1'b0;
        err_d       = 1'b0;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          wdata_d     = req_wdata;
          mem_addr_d  = req_addr & ~OFF_MASK;
          state_d     = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        beat_d = '0;
        cnt_d  = '0;
        if (we_q && mem_accW) begin
          state_d          = WR_BURST;
          mem_we_d         = 1'b1;
          mem_dinDstrobe_d = '0;
          mem_din_d        = wsub[0];
        end else if (!we_q && mem_accR) begin
          state_d  = RD_WAIT;
          mem_en_d = 1'b1;
        end
      end
      WR_BURST: begin
        // accW is deliberately not re-checked: once granted, the burst runs to completion
        if (mem_dinDstrobe_q == LAST_SUB) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
        end else begin
          mem_we_d         = 1'b1;
          mem_dinDstrobe_d = mem_dinDstrobe_q + 1'b1;
          mem_din_d        = wsub[mem_dinDstrobe_q + 1'b1];
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_dready) begin
          for (int k = 0; k < SUBBLOCKS; k++) begin
            if (mem_doutDstrobe == SUB_LOG2'(k)) resp_rdata_d[k*SW +: SW] = mem_dout;
          end
          if (strobe_bad) err_d = 1'b1;
          beat_d = beat_q + 1'b1;
        end
        // A final beat arriving on the timeout cycle still counts as a completed read
        if (mem_dready && beat_q == LAST_SUB) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q | strobe_bad;
        end else if (timed_out) begin
          state_d      = DONE;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        resp_err_d  = 1'b0;
        err_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      err_q            <= 1'b0;
      beat_q           <= '0;
      cnt_q            <= '0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      mem_addr_q       <= '0;
      mem_en_q         <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_dinDstrobe_q <= '0;
      mem_din_q        <= '0;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      wdata_q          <= wdata_d;
      err_q            <= err_d;
      beat_q           <= beat_d;
      cnt_q            <= cnt_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_addr_q       <= mem_addr_d;
      mem_en_q         <= mem_en_d;
      mem_we_q         <= mem_we_d;
      mem_dinDstrobe_q <= mem_dinDstrobe_d;
      mem_din_q        <= mem_din_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_dinDstrobe = mem_dinDstrobe_q;
  assign mem_din        = mem_din_q;

endmodule
